// File: rtl/hysteresis_pkg.sv
// hysteresis_pkg: pixel classes, FSM states and default edge codes shared by the hysteresis stream unit
package hysteresis_pkg;
   typedef enum logic [1:0] {CLS_NONE, CLS_WEAK, CLS_STRONG} pix_class_t;
   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SCAN, S_CHECK, S_OUT} state_t;
   localparam int DEF_WEAK_PIXEL = 75;
   localparam int DEF_STRONG_PIXEL = 255;
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
   function automatic int iabs(input int v);
      return (v < 0) ? -v : v;
   endfunction
endpackage

// File: rtl/hyst_neighbour_check.sv
// hyst_neighbour_check: flags whether pixel (row,col) has an in-frame STRONG neighbour
module hyst_neighbour_check
   import hysteresis_pkg::*;
#(
   parameter int HEIGHT = 5,
   parameter int WIDTH = 5,
   parameter int CONN8 = 1
) (
   input  pix_class_t [HEIGHT*WIDTH-1:0] cls_mem,
   input  logic [idx_w(HEIGHT)-1:0]      row,
   input  logic [idx_w(WIDTH)-1:0]       col,
   output logic                          strong_nb
);
   // Only real pixels are visited, so frame edges never wrap
   always_comb begin
      strong_nb = 1'b0;
      for (int i = 0; i < HEIGHT*WIDTH; i++)
         if (cls_mem[i] == CLS_STRONG && i != int'(row) * WIDTH + int'(col) &&
             iabs(i / WIDTH - int'(row)) <= 1 && iabs(i % WIDTH - int'(col)) <= 1 &&
             (CONN8 != 0 || i / WIDTH == int'(row) || i % WIDTH == int'(col)))
            strong_nb = 1'b1;
   end
endmodule

// File: rtl/hysteresis_stream_unit.sv
// hysteresis_stream_unit: streaming hysteresis edge tracker; HYST_PASS_STATS_EN adds a pass_count output
module hysteresis_stream_unit
   import hysteresis_pkg::*;
#(
   parameter int HEIGHT = 5,
   parameter int WIDTH = 5,
   parameter int PIX_W = 8,
   parameter int WEAK_PIXEL = DEF_WEAK_PIXEL,
   parameter int STRONG_PIXEL = DEF_STRONG_PIXEL,
   parameter int CONN8 = 1,
   parameter int MAX_PASSES = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [PIX_W-1:0] in_pixel,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [PIX_W-1:0] out_pixel,
   output logic             busy,
   output logic             done
`ifdef HYST_PASS_STATS_EN
   ,
   output logic [$clog2(MAX_PASSES+1)-1:0] pass_count
`endif
);
   localparam int N = HEIGHT * WIDTH;
   localparam int IW = idx_w(N);
   localparam int RW = idx_w(HEIGHT);
   localparam int CW = idx_w(WIDTH);
   localparam int PCW = $clog2(MAX_PASSES + 1);
   localparam logic [PIX_W-1:0] WEAK_C = PIX_W'(WEAK_PIXEL);
   localparam logic [PIX_W-1:0] STRONG_C = PIX_W'(STRONG_PIXEL);

   state_t state, state_next;
   pix_class_t [N-1:0] cls_mem;
   pix_class_t in_cls;
   logic [IW-1:0] idx;
   logic [RW-1:0] row;
   logic [CW-1:0] col;
   logic [PCW-1:0] passes, pass_inc;
   logic changed, adv, last, strong_nb, promote;

   hyst_neighbour_check #(.HEIGHT(HEIGHT), .WIDTH(WIDTH), .CONN8(CONN8)) u_nb (
      .cls_mem  (cls_mem),
      .row      (row),
      .col      (col),
      .strong_nb(strong_nb)
   );

   assign last = idx == IW'(N - 1);
   assign pass_inc = passes + 1'b1;
   assign promote = state == S_SCAN && cls_mem[idx] == CLS_WEAK && strong_nb;
   assign in_cls = (in_pixel == STRONG_C) ? CLS_STRONG : (in_pixel == WEAK_C) ? CLS_WEAK : CLS_NONE;
   assign in_ready = state == S_LOAD;
   assign out_valid = state == S_OUT;
   assign out_pixel = (out_valid && cls_mem[idx] == CLS_STRONG) ? STRONG_C : '0;
   assign busy = state != S_IDLE;
   assign done = out_valid && out_ready && last;

   always_comb begin
      state_next = state;
      adv = 1'b0;
      case (state)
         S_IDLE: state_next = start ? S_LOAD : S_IDLE;
         S_LOAD: begin
            adv = in_valid;
            state_next = (in_valid && last) ? S_SCAN : S_LOAD;
         end
         S_SCAN: begin
            adv = 1'b1;
            state_next = last ? S_CHECK : S_SCAN;
         end
         S_CHECK: state_next = (changed && pass_inc < PCW'(MAX_PASSES)) ? S_SCAN : S_OUT;
         S_OUT: begin
            adv = out_ready;
            state_next = (out_ready && last) ? S_IDLE : S_OUT;
         end
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= S_IDLE;
         idx <= '0;
         row <= '0;
         col <= '0;
         passes <= '0;
         changed <= 1'b0;
      end else begin
         state <= state_next;
         if (adv) begin
            idx <= last ? '0 : idx + 1'b1;
            col <= (col == CW'(WIDTH - 1)) ? '0 : col + 1'b1;
            row <= last ? '0 : (col == CW'(WIDTH - 1)) ? row + 1'b1 : row;
         end
         if (state == S_IDLE && start) passes <= '0;
         if (state == S_CHECK) passes <= pass_inc;
         changed <= (state == S_CHECK || (state == S_IDLE && start)) ? 1'b0 : changed | promote;
      end
   end

   // Updates land before the next raster pixel is examined, so promotions chain within a pass
   always_ff @(posedge clk) begin
      if (in_ready && in_valid) cls_mem[idx] <= in_cls;
      else if (promote) cls_mem[idx] <= CLS_STRONG;
   end

`ifdef HYST_PASS_STATS_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) pass_count <= '0;
      else if (state == S_IDLE && start) pass_count <= '0;
      else if (state == S_CHECK && state_next == S_OUT) pass_count <= pass_inc;
   end
`endif
endmodule
